mmc3_bus_frontend: RTL
======================

// Module: mmc3_bus_frontend
// PURPOSE
//  Front end between the raw cartridge-edge signals and the MMC3 mapper core. Synchronises M2 and PPU A12
//  into the fast clock domain, turns each qualified CPU write to $8000-$FFFF into a single-cycle register-write
//  strobe with stable address/data, and emits a filtered A12 rising-edge pulse that clocks the scanline IRQ counter.
//  Sits directly upstream of the mapper: the mapper consumes wr_stb/wr_addr/wr_data and a12_rise, never raw pins.
// PARAMETERS
//  SYNC_STAGES   2  synchroniser depth for m2 and ppu_a12 (>=2)
//  M2_MIN_HIGH   4  clk_ppu cycles m2_s must stay high before the M2 phase counts as a real CPU cycle
//  A12_LOW_M2    3  M2 falling edges A12 must stay low before a rising A12 is accepted
//  CNT_W         4  width of the internal high-time and low-time counters (must hold M2_MIN_HIGH, A12_LOW_M2)
// PORTS
//  clk_ppu     in   1   system clock; all outputs synchronous to it
//  rst_n       in   1   asynchronous, active-low reset
//  m2          in   1   CPU M2 phase, asynchronous to clk_ppu
//  romsel      in   1   high when CPU addresses $8000-$FFFF
//  cpu_rw      in   1   1 = read, 0 = write
//  cpu_addr    in   15  CPU A14..A0
//  cpu_data_i  in   8   CPU data bus
//  ppu_a12     in   1   PPU A12, asynchronous to clk_ppu
//  wr_stb      out  1   one-cycle pulse: committed mapper register write
//  wr_addr     out  15  address of committed write; held until next wr_stb
//  wr_data     out  8   data of committed write; held until next wr_stb
//  m2_fall     out  1   one-cycle pulse at end of every qualified CPU cycle
//  a12_rise    out  1   one-cycle pulse: filtered A12 rising edge
// BEHAVIOUR
//  Reset: all outputs 0; synchroniser flops, counters, snapshot and FSM cleared; FSM = IDLE. Async assert, sync release.
//  Sync: m2_s, a12_s = last stage of SYNC_STAGES-flop chains; edge detect against one further registered copy.
//  CPU FSM (states IDLE, QUAL, HIGH):
//   IDLE: m2_s==1 -> QUAL, hi_cnt<=1.
//   QUAL: m2_s==0 -> IDLE (glitch, no output). hi_cnt==M2_MIN_HIGH-1 and m2_s==1 -> HIGH. Else hi_cnt++.
//   HIGH: every cycle m2_s==1, snapshot {romsel,cpu_rw,cpu_addr,cpu_data_i} <= raw inputs (last sample before fall wins).
//         m2_s==0 -> IDLE, m2_fall=1 that cycle; if snapshot romsel==1 && rw==0 also wr_stb=1, wr_addr/wr_data<=snapshot.
//  Latency: wr_stb/m2_fall assert 1 clk after the cycle m2_s is seen low (SYNC_STAGES+1 clks after raw M2 falls).
//  Exactly one wr_stb per CPU write cycle; reads, $0000-$7FFF writes and glitches produce no wr_stb.
//  hi_cnt saturates; a M2 high phase of any length yields one m2_fall.
//  A12 filter: lo_cnt (CNT_W bits) cleared while a12_s==1; while a12_s==0 increments on each m2_fall, saturating at
//   A12_LOW_M2. On a12_s 0->1: a12_rise=1 for one clk iff lo_cnt>=A12_LOW_M2; lo_cnt cleared. Rising edge with
//   lo_cnt<A12_LOW_M2 (e.g. sprite fetch toggling) is suppressed.
//  Simultaneous m2_fall and a12_s rise: rise is judged on lo_cnt before this cycle's increment.
//  First A12 rise after reset is suppressed unless A12_LOW_M2 M2 falls elapsed with A12 low.
//  Reset mid-cycle: partial write discarded; no strobe emitted on release even if M2 then falls.
//  Widths: no truncation; counters compare as unsigned CNT_W.
// TESTING
//  1 Write $8001<=$5A, M2 high 10 clks -> one wr_stb, wr_addr=15'h0001, wr_data=8'h5A, m2_fall same clk.
//  2 Read at $C000 and write at $6000 (romsel=0) -> m2_fall each cycle, wr_stb never asserts, wr_addr/wr_data unchanged.
//  3 M2 glitch high for 2 clks (<M2_MIN_HIGH) -> no m2_fall, no wr_stb; FSM back in IDLE.
//  4 A12 low over 3 m2_falls then high -> single a12_rise; A12 low over 1 m2_fall then high -> no pulse.
//  5 Data changes $11->$22 late in M2 high, before fall -> wr_data=8'h22.
//  6 Assert rst_n=0 mid M2-high write, release while M2 still high -> no wr_stb; all outputs 0 during reset.

Source files
------------

// File: rtl/mmc3_bus_frontend.sv
`default_nettype none
// ============================================================================
// Module   : mmc3_bus_frontend
// Brief    : Cartridge-edge front end for MMC3: M2/A12 sync, qualified CPU
//            write strobes and filtered A12 rising-edge pulses.
// Revision : 1.0 - initial release
// ============================================================================
module mmc3_bus_frontend #(
    parameter int SYNC_STAGES = 2,
    parameter int M2_MIN_HIGH = 4,
    parameter int A12_LOW_M2  = 3,
    parameter int CNT_W       = 4
) (
    input  logic        clk_ppu,
    input  logic        rst_n,
    input  logic        m2,
    input  logic        romsel,
    input  logic        cpu_rw,
    input  logic [14:0] cpu_addr,
    input  logic [7:0]  cpu_data_i,
    input  logic        ppu_a12,
    output logic        wr_stb,
    output logic [14:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        m2_fall,
    output logic        a12_rise
);

    localparam logic [1:0]       c_st_idle = 2'd0;
    localparam logic [1:0]       c_st_qual = 2'd1;
    localparam logic [1:0]       c_st_high = 2'd2;
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_hi_last = CNT_W'(M2_MIN_HIGH - 1);
    localparam logic [CNT_W-1:0] c_lo_min  = CNT_W'(A12_LOW_M2);

    logic [1:0]             r_rst_pipe;
    logic                   w_rst_n;
    logic [SYNC_STAGES-1:0] r_m2_sync;
    logic [SYNC_STAGES-1:0] r_a12_sync;
    logic [SYNC_STAGES-1:0] r_sync_vld;
    logic                   w_m2_s;
    logic                   w_a12_s;
    logic                   r_a12_d;
    logic                   r_armed;
    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [CNT_W-1:0]       r_hi_cnt;
    logic [CNT_W-1:0]       w_hi_cnt_nxt;
    logic                   w_commit;
    logic [CNT_W-1:0]       r_lo_cnt;
    logic                   r_snap_romsel;
    logic                   r_snap_rw;
    logic [14:0]            r_snap_addr;
    logic [7:0]             r_snap_data;
    logic                   r_wr_stb;
    logic [14:0]            r_wr_addr;
    logic [7:0]             r_wr_data;
    logic                   r_m2_fall;
    logic                   r_a12_rise;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk_ppu or negedge rst_n) begin
        if (!rst_n) r_rst_pipe <= 2'b00;
        else        r_rst_pipe <= {r_rst_pipe[0], 1'b1};
    end
    assign w_rst_n = r_rst_pipe[1];

    assign w_m2_s  = r_m2_sync[SYNC_STAGES-1];
    assign w_a12_s = r_a12_sync[SYNC_STAGES-1];

    // A CPU cycle only qualifies after M2 has been seen low with a filled
    // synchroniser, so a phase already in progress at reset release is dropped.
    always_ff @(posedge clk_ppu or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_m2_sync  <= '0;
            r_a12_sync <= '0;
            r_sync_vld <= '0;
            r_a12_d    <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_m2_sync  <= {r_m2_sync[SYNC_STAGES-2:0], m2};
            r_a12_sync <= {r_a12_sync[SYNC_STAGES-2:0], ppu_a12};
            r_sync_vld <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
            r_a12_d    <= w_a12_s;
            r_armed    <= r_armed | (r_sync_vld[SYNC_STAGES-1] & ~w_m2_s);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_hi_cnt_nxt = r_hi_cnt;
        w_commit     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_m2_s && r_armed) begin
                    w_state_nxt  = c_st_qual;
                    w_hi_cnt_nxt = c_one;
                end
            end
            c_st_qual: begin
                if (!w_m2_s)                   w_state_nxt  = c_st_idle;
                else if (r_hi_cnt >= c_hi_last) w_state_nxt  = c_st_high;
                else                            w_hi_cnt_nxt = r_hi_cnt + c_one;
            end
            c_st_high: begin
                if (!w_m2_s) begin
                    w_state_nxt = c_st_idle;
                    w_commit    = 1'b1;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk_ppu or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state       <= c_st_idle;
            r_hi_cnt      <= '0;
            r_snap_romsel <= 1'b0;
            r_snap_rw     <= 1'b0;
            r_snap_addr   <= '0;
            r_snap_data   <= '0;
            r_wr_stb      <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_m2_fall     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hi_cnt  <= w_hi_cnt_nxt;
            // Sample the bus whenever M2 is high so the final pre-fall value wins.
            if (w_m2_s) begin
                r_snap_romsel <= romsel;
                r_snap_rw     <= cpu_rw;
                r_snap_addr   <= cpu_addr;
                r_snap_data   <= cpu_data_i;
            end
            r_m2_fall <= w_commit;
            r_wr_stb  <= w_commit & r_snap_romsel & ~r_snap_rw;
            if (w_commit && r_snap_romsel && !r_snap_rw) begin
                r_wr_addr <= r_snap_addr;
                r_wr_data <= r_snap_data;
            end
        end
    end

    // The rise decision uses lo_cnt before any same-cycle increment.
    always_ff @(posedge clk_ppu or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_lo_cnt   <= '0;
            r_a12_rise <= 1'b0;
        end else begin
            r_a12_rise <= w_a12_s & ~r_a12_d & (r_lo_cnt >= c_lo_min);
            if (w_a12_s)
                r_lo_cnt <= '0;
            else if (r_m2_fall && (r_lo_cnt < c_lo_min))
                r_lo_cnt <= r_lo_cnt + c_one;
        end
    end

    assign wr_stb   = r_wr_stb;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign m2_fall  = r_m2_fall;
    assign a12_rise = r_a12_rise;

endmodule
`default_nettype wire
